// File: rtl/mac_accumulator.sv
// Signed multiply-accumulate of N x*w products plus a bias scaled into product format.
// Latency: out_valid rises on the edge that accepts the Nth beat; the minimum vector period is N+1 cycles.
// Backpressure: in_ready drops while a result waits in DONE and stays low until out_valid && out_ready.
module mac_accumulator #(
    parameter int N     = 4,
    parameter int WIDTH = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic signed [WIDTH-1:0]       x,
    input  logic signed [WIDTH-1:0]       w,
    input  logic signed [WIDTH-1:0]       bias,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic signed [2*WIDTH+N-1:0]   acc_result
);

    localparam int AW = 2*WIDTH + N;
    localparam int F  = (WIDTH == 8) ? 5 : (WIDTH == 16) ? 10 : 20;
    localparam int CW = (N > 1) ? $clog2(N+1) : 1;
    localparam logic [CW-1:0] LAST = CW'(N-1);

    typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

    state_t                   state, state_nxt;
    logic [CW-1:0]            count, count_nxt;
    logic signed [AW-1:0]     acc, acc_nxt;
    logic signed [2*WIDTH-1:0] prod;
    logic signed [AW-1:0]     prod_ext;
    logic signed [AW-1:0]     bias_ext;
    logic                     accept;

    assign prod     = x * w;
    assign prod_ext = {{N{prod[2*WIDTH-1]}}, prod};
    // Bias is Q(I).(F); shifting by F aligns it to the product's 2F fractional bits.
    assign bias_ext = {{(AW-WIDTH){bias[WIDTH-1]}}, bias} <<< F;

    assign in_ready   = (state != DONE);
    assign accept     = in_valid && in_ready;
    assign out_valid  = (state == DONE);
    assign acc_result = acc;

    always_comb begin
        state_nxt = state;
        count_nxt = count;
        acc_nxt   = acc;
        case (state)
            IDLE: begin
                if (accept) begin
                    acc_nxt   = bias_ext + prod_ext;
                    count_nxt = CW'(1);
                    state_nxt = (N == 1) ? DONE : ACCUM;
                end
            end
            ACCUM: begin
                if (accept) begin
                    acc_nxt   = acc + prod_ext;
                    count_nxt = count + CW'(1);
                    if (count == LAST) begin
                        state_nxt = DONE;
                    end
                end
            end
            DONE: begin
                // acc is left untouched so the result stays stable while stalled.
                if (out_ready) begin
                    state_nxt = IDLE;
                    count_nxt = '0;
                end
            end
            default: begin
                state_nxt = IDLE;
                count_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            count <= '0;
            acc   <= '0;
        end else begin
            state <= state_nxt;
            count <= count_nxt;
            acc   <= acc_nxt;
        end
    end

endmodule
